// File: rtl/bus_pkg.sv
// Shared definitions for the 6502 bus controller: default address map,
// device indices and the controller state encoding.
package bus_pkg;

  // Default address map (base / compare mask pairs)
  localparam logic [15:0] RAM_BASE   = 16'h0000;
  localparam logic [15:0] RAM_MASK   = 16'hE000;
  localparam logic [15:0] UART_BASE  = 16'hD010;
  localparam logic [15:0] UART_MASK  = 16'hFFFC;
  localparam logic [15:0] BASIC_BASE = 16'hE000;
  localparam logic [15:0] BASIC_MASK = 16'hF000;
  localparam logic [15:0] ROM_BASE   = 16'hFF00;
  localparam logic [15:0] ROM_MASK   = 16'hFF00;

  // Device slot of each region in the packed DEV_* vectors
  localparam int DEV_RAM   = 0;
  localparam int DEV_UART  = 1;
  localparam int DEV_BASIC = 2;
  localparam int DEV_ROM   = 3;

  // Controller state: RST while the core is held in reset, RUN for normal
  // accesses, WAIT while a slow device stretches the current access.
  typedef enum logic [1:0] {
    RST  = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_ctrl_clken_gen.sv
// Free-running clock-enable generator: one-clock tick every CLK_DIV clocks.
// Shared by the CPU bus controller, video timing and UART baud logic.
module clken_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next divider count: 0..CLK_DIV-1 then wrap
  always_comb begin
    count_d = count_q;
    if (count_q == LAST) begin
      count_d = {CW{1'b0}};
    end else begin
      count_d = count_q + CW'(1'b1);
    end
  end

  // Divider counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/bus_ctrl.sv
// 6502 bus controller: CPU clock enable, power-up reset, registered bus
// capture, N-way address decode with per-device wait states, and the
// registered read-data mux.
module bus_ctrl
  import bus_pkg::*;
#(
  parameter int                    CLK_DIV   = 25,
  parameter int                    RST_TICKS = 63,
  parameter int                    NUM_DEV   = 4,
  parameter logic [NUM_DEV*16-1:0] DEV_BASE  = {ROM_BASE, BASIC_BASE, UART_BASE, RAM_BASE},
  parameter logic [NUM_DEV*16-1:0] DEV_MASK  = {ROM_MASK, BASIC_MASK, UART_MASK, RAM_MASK},
  parameter logic [NUM_DEV*2-1:0]  DEV_WAIT  = {2'd0, 2'd1, 2'd0, 2'd0}
) (
  input  logic                 clk25,
  input  logic                 rst_n,
  input  logic [15:0]          cpu_ab,
  input  logic [7:0]           cpu_do,
  input  logic                 cpu_we,
  output logic                 cpu_rdy,
  output logic                 cpu_reset,
  output logic [7:0]           cpu_di,
  output logic [15:0]          bus_ab,
  output logic [7:0]           bus_dout,
  output logic                 bus_we,
  output logic                 bus_stb,
  output logic [NUM_DEV-1:0]   dev_cs,
  input  logic [NUM_DEV*8-1:0] dev_din
);

  localparam logic [7:0] RST_LAST = 8'(RST_TICKS - 1);

  bus_state_e   state_q, state_d;
  logic [7:0]   rst_cnt_q, rst_cnt_d;
  logic [1:0]   wait_cnt_q, wait_cnt_d;
  logic         cpu_reset_q, cpu_reset_d;
  logic [7:0]   cpu_di_q, cpu_di_d;
  logic [15:0]  bus_ab_q, bus_ab_d;
  logic [7:0]   bus_dout_q, bus_dout_d;
  logic         bus_we_q, bus_we_d;
  logic         bus_stb_q, bus_stb_d;

  logic               tick_s;
  logic               rdy_s;
  logic [NUM_DEV-1:0] cs_s;
  logic               hit_any_s;
  logic [7:0]         rdata_s;
  logic [1:0]         dev_wait_s;

  clken_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clken (
    .clk   (clk25),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  // The core advances on every tick except while a slow device stretches the access
  assign rdy_s = tick_s & (state_q != WAIT);

  // Priority address decode of the captured address: lowest index wins
  always_comb begin
    cs_s       = {NUM_DEV{1'b0}};
    hit_any_s  = 1'b0;
    rdata_s    = 8'hFF;
    dev_wait_s = 2'd0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (!hit_any_s && ((bus_ab_q & DEV_MASK[16*i +: 16]) == DEV_BASE[16*i +: 16])) begin
        cs_s[i]    = 1'b1;
        hit_any_s  = 1'b1;
        rdata_s    = dev_din[8*i +: 8];
        dev_wait_s = DEV_WAIT[2*i +: 2];
      end else begin
        cs_s[i]    = 1'b0;
      end
    end
  end

  // Next-state logic: reset sequencing, bus capture and wait-state stretching
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    cpu_reset_d = cpu_reset_q;
    cpu_di_d    = cpu_di_q;
    bus_ab_d    = bus_ab_q;
    bus_dout_d  = bus_dout_q;
    bus_we_d    = bus_we_q;
    bus_stb_d   = 1'b0;
    case (state_q)
      RST: begin
        if (tick_s) begin
          rst_cnt_d = rst_cnt_q + 8'd1;
          if (rst_cnt_q == RST_LAST) begin
            state_d     = RUN;
            cpu_reset_d = 1'b0;
          end else begin
            state_d     = RST;
          end
        end else begin
          state_d = RST;
        end
      end
      RUN: begin
        if (rdy_s) begin
          // Closing edge of the previous access doubles as capture of the next
          bus_ab_d   = cpu_ab;
          bus_dout_d = cpu_do;
          bus_we_d   = cpu_we;
          cpu_di_d   = rdata_s;
          bus_stb_d  = 1'b1;
        end else if (bus_stb_q && (dev_wait_s != 2'd0)) begin
          wait_cnt_d = dev_wait_s;
          state_d    = WAIT;
        end else begin
          state_d    = RUN;
        end
      end
      WAIT: begin
        if (tick_s) begin
          wait_cnt_d = wait_cnt_q - 2'd1;
          // A counter of zero here is corrupt; release the bus rather than stall
          if (wait_cnt_q <= 2'd1) begin
            state_d = RUN;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d     = RST;
        rst_cnt_d   = 8'd0;
        wait_cnt_d  = 2'd0;
        cpu_reset_d = 1'b1;
      end
    endcase
  end

  // Controller and bus registers
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST;
      rst_cnt_q   <= 8'd0;
      wait_cnt_q  <= 2'd0;
      cpu_reset_q <= 1'b1;
      cpu_di_q    <= 8'hFF;
      bus_ab_q    <= 16'h0000;
      bus_dout_q  <= 8'h00;
      bus_we_q    <= 1'b0;
      bus_stb_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_di_q    <= cpu_di_d;
      bus_ab_q    <= bus_ab_d;
      bus_dout_q  <= bus_dout_d;
      bus_we_q    <= bus_we_d;
      bus_stb_q   <= bus_stb_d;
    end
  end

  assign cpu_rdy   = rdy_s;
  assign cpu_reset = cpu_reset_q;
  assign cpu_di    = cpu_di_q;
  assign bus_ab    = bus_ab_q;
  assign bus_dout  = bus_dout_q;
  assign bus_we    = bus_we_q & hit_any_s;
  assign bus_stb   = bus_stb_q;
  assign dev_cs    = cs_s;

endmodule

// File: tb/tb_bus_ctrl.sv
// Self-checking bench for bus_ctrl with the default 4-device map.
module tb_bus_ctrl;
  import bus_pkg::*;

  localparam int CLK_DIV   = 25;
  localparam int RST_TICKS = 63;

  logic        clk25 = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] cpu_ab = 16'h0000;
  logic [7:0]  cpu_do = 8'h00;
  logic        cpu_we = 1'b0;
  logic        cpu_rdy, cpu_reset, bus_we, bus_stb;
  logic [7:0]  cpu_di, bus_dout;
  logic [15:0] bus_ab;
  logic [3:0]  dev_cs;
  logic [31:0] dev_din = 32'h0000_0000;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] prev_ab  = 16'h0000;

  // Reference address map, in device order 0..3
  logic [15:0] map_base [4];
  logic [15:0] map_mask [4];
  int          map_wait [4];

  bus_ctrl dut (
    .clk25     (clk25),
    .rst_n     (rst_n),
    .cpu_ab    (cpu_ab),
    .cpu_do    (cpu_do),
    .cpu_we    (cpu_we),
    .cpu_rdy   (cpu_rdy),
    .cpu_reset (cpu_reset),
    .cpu_di    (cpu_di),
    .bus_ab    (bus_ab),
    .bus_dout  (bus_dout),
    .bus_we    (bus_we),
    .bus_stb   (bus_stb),
    .dev_cs    (dev_cs),
    .dev_din   (dev_din)
  );

  always #5 clk25 = ~clk25;

  function automatic int model_dev(input logic [15:0] a);
    for (int i = 0; i < 4; i++) begin
      if ((a & map_mask[i]) == map_base[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a, input logic [31:0] din);
    int d;
    d = model_dev(a);
    if (d < 0) return 8'hFF;
    return din[8*d +: 8];
  endfunction

  function automatic logic [3:0] model_cs(input logic [15:0] a);
    int d;
    d = model_dev(a);
    if (d < 0) return 4'b0000;
    return 4'b0001 << d;
  endfunction

  task automatic check_reset_values(input string tag);
    n_checks++; if (cpu_rdy   !== 1'b0)     begin n_fail++; $display("FAIL %s cpu_rdy got=%b exp=0", tag, cpu_rdy); end
    n_checks++; if (cpu_reset !== 1'b1)     begin n_fail++; $display("FAIL %s cpu_reset got=%b exp=1", tag, cpu_reset); end
    n_checks++; if (cpu_di    !== 8'hFF)    begin n_fail++; $display("FAIL %s cpu_di got=%h exp=ff", tag, cpu_di); end
    n_checks++; if (bus_ab    !== 16'h0000) begin n_fail++; $display("FAIL %s bus_ab got=%h exp=0000", tag, bus_ab); end
    n_checks++; if (bus_dout  !== 8'h00)    begin n_fail++; $display("FAIL %s bus_dout got=%h exp=00", tag, bus_dout); end
    n_checks++; if (bus_we    !== 1'b0)     begin n_fail++; $display("FAIL %s bus_we got=%b exp=0", tag, bus_we); end
    n_checks++; if (bus_stb   !== 1'b0)     begin n_fail++; $display("FAIL %s bus_stb got=%b exp=0", tag, bus_stb); end
    n_checks++; if (dev_cs    !== 4'b0001)  begin n_fail++; $display("FAIL %s dev_cs got=%b exp=0001", tag, dev_cs); end
  endtask

  // Release reset and follow the reset sequence cycle by cycle
  task automatic reset_sequence();
    @(negedge clk25);
    rst_n = 1'b1;
    for (int n = 1; n <= RST_TICKS * CLK_DIV + 5; n++) begin
      @(negedge clk25);
      n_checks++;
      if (cpu_rdy !== ((n % CLK_DIV) == CLK_DIV - 1)) begin
        n_fail++; $display("FAIL rdy_period clk=%0d got=%b exp=%b", n, cpu_rdy, ((n % CLK_DIV) == CLK_DIV - 1));
      end
      n_checks++;
      if (cpu_reset !== (n < RST_TICKS * CLK_DIV)) begin
        n_fail++; $display("FAIL reset_len clk=%0d got=%b exp=%b", n, cpu_reset, (n < RST_TICKS * CLK_DIV));
      end
      n_checks++;
      if (bus_stb !== 1'b0) begin
        n_fail++; $display("FAIL stb_in_reset clk=%0d got=%b exp=0", n, bus_stb);
      end
      if (n == RST_TICKS * CLK_DIV - 1) begin
        n_checks++; if (cpu_di !== 8'hFF)    begin n_fail++; $display("FAIL di_before_read got=%h exp=ff", cpu_di); end
        n_checks++; if (bus_ab !== 16'h0000) begin n_fail++; $display("FAIL ab_in_reset got=%h exp=0000", bus_ab); end
      end
    end
    prev_ab = 16'h0000;
  endtask

  task automatic sync_rdy();
    int n;
    n = 0;
    while (cpu_rdy !== 1'b1 && n < 100) begin
      @(negedge clk25);
      n++;
    end
    n_checks++;
    if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL sync_rdy timeout got=%b exp=1", cpu_rdy); end
  endtask

  // One CPU access; din is the device data seen when the previous access closes
  task automatic access(input logic [15:0] ab, input logic [7:0] dout, input logic we,
                        input logic [31:0] din, output int span);
    logic [7:0] exp_di;
    int d, w, n, extra, held_bad;
    bit done;
    sync_rdy();
    dev_din = din;
    cpu_ab  = ab;
    cpu_do  = dout;
    cpu_we  = we;
    exp_di  = model_read(prev_ab, din);
    d = model_dev(ab);
    w = (d < 0) ? 0 : map_wait[d];
    @(posedge clk25);
    @(negedge clk25);
    n_checks++; if (cpu_di !== exp_di)             begin n_fail++; $display("FAIL read_data ab=%h got=%h exp=%h", prev_ab, cpu_di, exp_di); end
    n_checks++; if (bus_ab !== ab)                 begin n_fail++; $display("FAIL capture_ab got=%h exp=%h", bus_ab, ab); end
    n_checks++; if (bus_dout !== dout)             begin n_fail++; $display("FAIL capture_do got=%h exp=%h", bus_dout, dout); end
    n_checks++; if (bus_we !== (we && d >= 0))     begin n_fail++; $display("FAIL bus_we ab=%h got=%b exp=%b", ab, bus_we, (we && d >= 0)); end
    n_checks++; if (dev_cs !== model_cs(ab))       begin n_fail++; $display("FAIL dev_cs ab=%h got=%b exp=%b", ab, dev_cs, model_cs(ab)); end
    n_checks++; if (bus_stb !== 1'b1)              begin n_fail++; $display("FAIL stb_after_capture got=%b exp=1", bus_stb); end
    n = 0; extra = 0; held_bad = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk25);
      n++;
      if (bus_stb === 1'b1) extra++;
      if (bus_ab !== ab || bus_dout !== dout) held_bad++;
      if (cpu_rdy === 1'b1) done = 1'b1;
    end
    n_checks++; if (n != CLK_DIV * (1 + w) - 1) begin n_fail++; $display("FAIL access_len ab=%h got=%0d exp=%0d", ab, n + 1, CLK_DIV * (1 + w)); end
    n_checks++; if (extra != 0)    begin n_fail++; $display("FAIL single_stb ab=%h got=%0d extra exp=0", ab, extra); end
    n_checks++; if (held_bad != 0) begin n_fail++; $display("FAIL bus_hold ab=%h got=%0d changes exp=0", ab, held_bad); end
    span    = n + 1;
    prev_ab = ab;
  endtask

  task automatic test_reset();
    cpu_ab = 16'hFF00;
    cpu_we = 1'b1;
    cpu_do = 8'hA5;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk25);
    check_reset_values("por");
    reset_sequence();
  endtask

  task automatic test_read();
    int span;
    access(16'h0123, 8'h00, 1'b0, $urandom, span);
    access(16'h0123, 8'h00, 1'b0, {$urandom_range(0, 16'hFFFF), 8'hC3, 8'h5A}, span);
    n_checks++; if (cpu_di !== 8'h5A) begin n_fail++; $display("FAIL read_dev0 got=%h exp=5a", cpu_di); end
  endtask

  task automatic test_wait_state();
    int span;
    access(16'hE010, 8'h00, 1'b0, $urandom, span);
    n_checks++; if (span != 50)          begin n_fail++; $display("FAIL wait_span got=%0d exp=50", span); end
    n_checks++; if (bus_ab !== 16'hE010) begin n_fail++; $display("FAIL wait_hold_ab got=%h exp=e010", bus_ab); end
  endtask

  task automatic test_write();
    int span;
    access(16'hD012, 8'h8D, 1'b1, $urandom, span);
    n_checks++; if (dev_cs !== 4'b0010) begin n_fail++; $display("FAIL write_cs got=%b exp=0010", dev_cs); end
    n_checks++; if (bus_we !== 1'b1)     begin n_fail++; $display("FAIL write_we got=%b exp=1", bus_we); end
    n_checks++; if (bus_dout !== 8'h8D)  begin n_fail++; $display("FAIL write_do got=%h exp=8d", bus_dout); end
  endtask

  task automatic test_unmapped();
    int span;
    access(16'hC000, 8'h55, 1'b1, $urandom, span);
    n_checks++; if (dev_cs !== 4'b0000) begin n_fail++; $display("FAIL unmapped_cs got=%b exp=0000", dev_cs); end
    n_checks++; if (bus_we !== 1'b0)    begin n_fail++; $display("FAIL unmapped_we got=%b exp=0", bus_we); end
    access(16'h0040, 8'h00, 1'b0, 32'h1234_5678, span);
    n_checks++; if (cpu_di !== 8'hFF)   begin n_fail++; $display("FAIL unmapped_read got=%h exp=ff", cpu_di); end
  endtask

  task automatic test_back_to_back();
    int span;
    logic [15:0] a;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0:       a = {3'b000, 13'($urandom)};
        1:       a = {14'h3404, 2'($urandom)};
        2:       a = {4'hE, 12'($urandom)};
        3:       a = {8'hFF, 8'($urandom)};
        default: a = 16'($urandom);
      endcase
      access(a, 8'($urandom), 1'($urandom_range(0, 1)), $urandom, span);
    end
  endtask

  task automatic test_reset_midwait();
    sync_rdy();
    cpu_ab = 16'hE010;
    cpu_we = 1'b0;
    @(posedge clk25);
    repeat (10) @(negedge clk25);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midwait");
    repeat (3) @(negedge clk25);
    reset_sequence();
    test_read();
  endtask

  initial begin
    map_base[DEV_RAM]   = RAM_BASE;   map_mask[DEV_RAM]   = RAM_MASK;   map_wait[DEV_RAM]   = 0;
    map_base[DEV_UART]  = UART_BASE;  map_mask[DEV_UART]  = UART_MASK;  map_wait[DEV_UART]  = 0;
    map_base[DEV_BASIC] = BASIC_BASE; map_mask[DEV_BASIC] = BASIC_MASK; map_wait[DEV_BASIC] = 1;
    map_base[DEV_ROM]   = ROM_BASE;   map_mask[DEV_ROM]   = ROM_MASK;   map_wait[DEV_ROM]   = 0;
    test_reset();
    test_read();
    test_wait_state();
    test_write();
    test_unmapped();
    test_back_to_back();
    test_reset_midwait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_ctrl.md
Name: bus_ctrl

Overview:
- Parametrised CPU bus controller, placed between the 6502 core and the memory/peripheral devices.
- Generates the CPU clock enable (RDY), power-up reset, registered address/data/write capture, N-way address decode and the read-data mux.
- Extends the current scheme with per-device wait states, a single-cycle access strobe, configurable divider and reset length, and a configurable device count.

Parameters:
- CLK_DIV, 25, clk25 cycles per CPU enable; period is exactly CLK_DIV; legal range 2..256.
- RST_TICKS, 63, CPU enable ticks for which cpu_reset is held after rst_n deasserts; legal range 1..255.
- NUM_DEV, 4, number of decoded devices.
- DEV_BASE, {16'hFF00,16'hE000,16'hD010,16'h0000}, packed NUM_DEV*16 base addresses; device i occupies bits [16i+15:16i].
- DEV_MASK, {16'hFF00,16'hF000,16'hFFFC,16'hE000}, packed NUM_DEV*16 compare masks.
- DEV_WAIT, {2'd0,2'd1,2'd0,2'd0}, packed NUM_DEV*2 extra enable ticks per access.

Ports:
- clk25  in  1  master clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_ab  in  16  CPU address.
- cpu_do  in  8  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_rdy  out  1  CPU RDY / clock enable.
- cpu_reset  out  1  CPU reset, active high.
- cpu_di  out  8  registered read data to the CPU.
- bus_ab  out  16  captured address.
- bus_dout  out  8  captured write data.
- bus_we  out  1  captured write enable, level, qualified by any dev_cs.
- bus_stb  out  1  one-clk25 pulse marking a new access.
- dev_cs  out  NUM_DEV  one-hot chip selects.
- dev_din  in  NUM_DEV*8  device read data; device i on bits [8i+7:8i].

Behaviour:
- rst_n low (async) clears everything:
  - div counter = 0, reset counter = 0, wait_cnt = 0, state = RST.
  - cpu_rdy = 0, cpu_reset = 1, cpu_di = 8'hFF.
  - bus_ab = 0, bus_dout = 0, bus_we = 0, bus_stb = 0.
  - dev_cs follows the decode of bus_ab = 0 (device 0 on the default map).
- Divider: counts 0..CLK_DIV-1 and wraps. tick = (count == CLK_DIV-1), one clk25 wide, period exactly CLK_DIV.
- cpu_rdy = tick & (state != WAIT), combinational from registered state. It is also asserted during RST so the core can execute its reset sequence.
- State RST:
  - Reset counter increments on each tick.
  - When it reaches RST_TICKS: state -> RUN and cpu_reset falls on the same edge.
  - cpu_reset high for exactly RST_TICKS ticks.
- State RUN, on a clk25 edge where cpu_rdy = 1:
  - Capture: bus_ab <= cpu_ab, bus_dout <= cpu_do, bus_we <= cpu_we.
  - cpu_di <= read mux of the previous bus_ab.
  - bus_stb <= 1 on the following edge only.
- Decode (combinational from bus_ab):
  - hit_i = ((bus_ab & MASK_i) == BASE_i).
  - Lowest index wins on overlap; dev_cs one-hot or all-zero.
  - Read mux returns 8'hFF when no device is selected.
  - bus_we is forced to 0 when no device is selected.
- Wait states:
  - On the clk25 cycle of bus_stb, if the selected device has DEV_WAIT > 0: wait_cnt <= DEV_WAIT and state -> WAIT.
  - In WAIT, each tick decrements wait_cnt and cpu_rdy stays 0. At wait_cnt == 1 → 0, state -> RUN.
  - The next tick asserts cpu_rdy, so the access lasts (1 + DEV_WAIT) ticks.
  - Address, data and we are held stable throughout; bus_stb is not repeated.
- Reads return the device data present at the closing cpu_rdy edge. Devices have at most 1-clk latency, which is guaranteed since CLK_DIV ≥ 2.
- rst_n asserted mid-WAIT: immediate abort, full reset values.

Decomposition:
- Shared package bus_pkg:
  - address-map constants (RAM_BASE/MASK, UART_BASE/MASK, BASIC_BASE/MASK, ROM_BASE/MASK);
  - device index constants (DEV_RAM = 0, DEV_UART = 1, DEV_BASIC = 2, DEV_ROM = 3);
  - state enum {RST, RUN, WAIT}.
- One sub-module, clken_gen (the divider + tick; parameter CLK_DIV), reused by the video and UART baud logic.

Test Plan:
- rst_n low 3 clks, release, CLK_DIV = 25, RST_TICKS = 63 -> cpu_rdy pulses every 25 clk25 exactly; cpu_reset falls on the 63rd tick edge; cpu_di = 8'hFF before the first read.
- cpu_ab = 16'h0123, cpu_we = 0, dev0 drives 8'h5A -> dev_cs = 4'b0001; bus_stb one clk after capture; cpu_di = 8'h5A latched at the next cpu_rdy.
- cpu_ab = 16'hE010 (DEV_WAIT = 1) -> one tick with cpu_rdy = 0; access spans 50 clk25; bus_ab held 16'hE010 throughout; single bus_stb.
- cpu_ab = 16'hD012, cpu_we = 1, cpu_do = 8'h8D -> dev_cs = 4'b0010; bus_we = 1; bus_dout = 8'h8D; exactly one bus_stb.
- cpu_ab = 16'hC000 unmapped, cpu_we = 1 -> dev_cs = 0; bus_we = 0; read returns 8'hFF.
- rst_n pulsed low mid-WAIT -> all outputs take reset values asynchronously; after release, cpu_reset held for RST_TICKS ticks again.
